// File: rtl/huff_pkg.sv
// Shared Huffman definitions for huff_encoder / huff_decoder.
// Contents: table sizing constants, character type, table entry struct,
// decoder state enum, and a popcount helper for code masks.
package huff_pkg;
  localparam int MAX_CHAR_COUNT    = 3;
  localparam int MAX_STRING_LENGTH = 10;
  localparam int CODE_W            = MAX_CHAR_COUNT;
  localparam int LEN_W             = $clog2(CODE_W + 1);

  typedef logic [7:0] char_t;

  typedef struct packed {
    char_t             ch;
    logic [CODE_W-1:0] value;
    logic [CODE_W-1:0] mask;
  } huff_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_FLUSH, ST_ERROR} dec_state_t;

  // Code length of an entry: masks are contiguous ones from bit 0.
  function automatic logic [LEN_W-1:0] popcnt(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] p;
    p = '0;
    for (int i = 0; i < CODE_W; i++) p = p + LEN_W'(m[i]);
    return p;
  endfunction
endpackage

// File: rtl/huff_code_match.sv
// Combinational code lookup.
// tbl  : captured code table
// cand : candidate code, LSB-aligned (newest bit in bit 0)
// clen : candidate length in bits
// hit  : some entry matches (or single-symbol mode is active)
// ch   : character of the matching entry
module huff_code_match
  import huff_pkg::*;
(
  input  huff_entry_t       tbl [MAX_CHAR_COUNT],
  input  logic [CODE_W-1:0] cand,
  input  logic [LEN_W-1:0]  clen,
  output logic              hit,
  output char_t             ch
);
  always_comb begin
    int    nz;
    logic  masks_zero;
    char_t one_ch;
    hit        = 1'b0;
    ch         = '0;
    nz         = 0;
    masks_zero = 1'b1;
    one_ch     = '0;
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      if (tbl[i].ch != '0) begin
        nz     = nz + 1;
        one_ch = tbl[i].ch;
      end
      if (tbl[i].mask != '0) masks_zero = 1'b0;
    end
    // A one-character alphabet is sent as one arbitrary bit per character.
    if (masks_zero && nz == 1) begin
      hit = 1'b1;
      ch  = one_ch;
    end else begin
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
        if (!hit && popcnt(tbl[i].mask) == clen &&
            (tbl[i].value & tbl[i].mask) == cand) begin
          hit = 1'b1;
          ch  = tbl[i].ch;
        end
      end
    end
  end
endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman bitstream decoder.
// table_load + character/encoded_value/encoded_mask : capture code table
// bit_valid/bit_in/bit_last -> bit_ready           : one bit per cycle, MSB of code first
// char_valid/char_out <- char_ready                : decoded characters
// char_count : characters emitted this stream; done : clean end pulse; err : sticky error
module huff_decoder #(
  parameter int MAX_CHAR_COUNT    = huff_pkg::MAX_CHAR_COUNT,
  parameter int MAX_STRING_LENGTH = huff_pkg::MAX_STRING_LENGTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      table_load,
  input  logic [MAX_CHAR_COUNT-1:0][7:0]            character,
  input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_value,
  input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_mask,
  input  logic                                      bit_valid,
  input  logic                                      bit_in,
  input  logic                                      bit_last,
  output logic                                      bit_ready,
  output logic                                      char_valid,
  output logic [7:0]                                char_out,
  input  logic                                      char_ready,
  output logic [$clog2(MAX_STRING_LENGTH+1)-1:0]    char_count,
  output logic                                      done,
  output logic                                      err
);
  import huff_pkg::huff_entry_t;
  import huff_pkg::dec_state_t;
  import huff_pkg::ST_IDLE;
  import huff_pkg::ST_DECODE;
  import huff_pkg::ST_FLUSH;
  import huff_pkg::ST_ERROR;

  localparam int CODE_W = MAX_CHAR_COUNT;
  localparam int LEN_W  = $clog2(CODE_W + 1);
  localparam int CNT_W  = $clog2(MAX_STRING_LENGTH + 1);

  huff_entry_t       tbl [MAX_CHAR_COUNT];
  dec_state_t        state;
  // A stored prefix is never longer than CODE_W-1: a CODE_W-bit miss is an error.
  logic [CODE_W-2:0] acc;
  logic [LEN_W-1:0]  len;
  logic [CODE_W-1:0] cand;
  logic [LEN_W-1:0]  nlen;
  logic              hit;
  logic [7:0]        hit_ch;
  logic              accept;

  assign cand      = {acc, bit_in};
  assign nlen      = len + LEN_W'(1);
  assign bit_ready = (state == ST_DECODE) && (!char_valid || char_ready);
  // A table load wins over a bit presented in the same cycle.
  assign accept    = bit_valid && bit_ready && !table_load;

  huff_code_match u_match (
    .tbl  (tbl),
    .cand (cand),
    .clen (nlen),
    .hit  (hit),
    .ch   (hit_ch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHAR_COUNT; i++) tbl[i] <= '0;
      state      <= ST_IDLE;
      acc        <= '0;
      len        <= '0;
      char_valid <= 1'b0;
      char_out   <= '0;
      char_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (table_load) begin
      for (int i = 0; i < MAX_CHAR_COUNT; i++)
        tbl[i] <= '{ch: character[i], value: encoded_value[i], mask: encoded_mask[i]};
      state      <= ST_DECODE;
      acc        <= '0;
      len        <= '0;
      char_valid <= 1'b0;
      char_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (char_valid && char_ready) char_valid <= 1'b0;
      case (state)
        ST_DECODE: begin
          if (accept) begin
            if (hit) begin
              acc <= '0;
              len <= '0;
              if (char_count == CNT_W'(MAX_STRING_LENGTH)) begin
                err   <= 1'b1;
                state <= ST_ERROR;
              end else begin
                // Loads over a character consumed this same cycle: no bubble.
                char_out   <= hit_ch;
                char_valid <= 1'b1;
                char_count <= char_count + CNT_W'(1);
                if (bit_last) state <= ST_FLUSH;
              end
            end else if (bit_last || nlen == LEN_W'(CODE_W)) begin
              err   <= 1'b1;
              state <= ST_ERROR;
            end else begin
              acc <= cand[CODE_W-2:0];
              len <= nlen;
            end
          end
        end
        ST_FLUSH: begin
          if (char_valid && char_ready) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ERROR: char_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_decoder.sv
module tb_huff_decoder;
  localparam int N  = 3;
  localparam int MS = 10;

  logic              clk = 1'b0;
  logic              reset, table_load, bit_valid, bit_in, bit_last, char_ready;
  logic [N-1:0][7:0] character;
  logic [N-1:0][N-1:0] encoded_value, encoded_mask;
  logic              bit_ready, char_valid, done, err;
  logic [7:0]        char_out;
  logic [3:0]        char_count;

  always #5 clk = ~clk;

  huff_decoder dut (
    .clk(clk), .reset(reset), .table_load(table_load), .character(character),
    .encoded_value(encoded_value), .encoded_mask(encoded_mask),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last), .bit_ready(bit_ready),
    .char_valid(char_valid), .char_out(char_out), .char_ready(char_ready),
    .char_count(char_count), .done(done), .err(err)
  );

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  bit  stim[$];
  int  done_cnt = 0;
  bit  mon_en = 0;
  int  rdy_pct = 100;
  bit  hold_prev = 0;
  logic [7:0] hold_char;

  // Reference tables: 0 = {a:10, n:0, u:11}, 1 = {a:10, n:0}, 2 = single 'a'
  int tab_ch[3][3], tab_code[3][3], tab_len[3][3];
  int m_ch[3], m_code[3], m_len[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: drives sink readiness, pops the scoreboard on every handshake.
  initial forever begin
    @(negedge clk);
    char_ready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (mon_en) begin
      if (hold_prev) begin
        chk("bp_hold_valid", char_valid, 1);
        chk("bp_hold_char", char_out, hold_char);
      end
      if (char_valid && !char_ready) chk("bp_bit_ready", bit_ready, 0);
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_char actual=%0d required=none", char_out);
        end else chk("char", char_out, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
    hold_prev = mon_en && char_valid && !char_ready;
    hold_char = char_out;
  end

  // Stream of n bits, first bit taken from pattern[n-1].
  task automatic set_stim(input int n, input logic [31:0] pattern);
    stim.delete();
    for (int i = n - 1; i >= 0; i--) stim.push_back(pattern[i]);
  endtask

  task automatic load_table(input int t);
    @(negedge clk);
    mon_en = 0;
    for (int e = 0; e < N; e++) begin
      m_ch[e] = tab_ch[t][e]; m_code[e] = tab_code[t][e]; m_len[e] = tab_len[t][e];
      character[e]     = 8'(m_ch[e]);
      encoded_value[e] = N'(m_code[e]);
      encoded_mask[e]  = N'((1 << m_len[e]) - 1);
    end
    table_load = 1; bit_valid = 1; bit_in = 1'($urandom); bit_last = 0;
    @(negedge clk);
    table_load = 0; bit_valid = 0;
    done_cnt = 0; exp_q.delete(); mon_en = 1;
  endtask

  // Reference decode from the code table: prefix matching on the bit history.
  task automatic model(output int nacc, output int eerr, output int edone, output int ecnt);
    int code, l, hit, nz, allz, sidx;
    code = 0; l = 0; nacc = 0; eerr = 0; edone = 0; ecnt = 0;
    nz = 0; allz = 1; sidx = 0;
    for (int e = 0; e < N; e++) begin
      if (m_ch[e] != 0) begin nz++; sidx = e; end
      if (m_len[e] != 0) allz = 0;
    end
    for (int i = 0; i < stim.size(); i++) begin
      bit last;
      last = (i == stim.size() - 1);
      nacc = i + 1;
      code = code * 2 + int'(stim[i]); l++;
      hit = -1;
      if (allz && nz == 1) hit = sidx;
      else for (int e = 0; e < N; e++)
        if (hit < 0 && m_len[e] == l && m_code[e] == code) hit = e;
      if (hit >= 0) begin
        if (ecnt == MS) begin eerr = 1; break; end
        exp_q.push_back(8'(m_ch[hit]));
        ecnt++; code = 0; l = 0;
        if (last) begin edone = 1; break; end
      end else if (last || l == N) begin
        eerr = 1; break;
      end
    end
  endtask

  task automatic run_stream(input string name);
    int nacc, eerr, edone, ecnt, w;
    bit got, timed_out;
    model(nacc, eerr, edone, ecnt);
    timed_out = 0;
    for (int i = 0; i < nacc && !timed_out; i++) begin
      @(negedge clk);
      bit_valid = 1; bit_in = stim[i]; bit_last = (i == stim.size() - 1);
      got = 0; w = 0;
      while (!got) begin
        #2;
        if (bit_ready) got = 1;
        else if (++w > 60) begin
          checks++; failures++; timed_out = 1;
          $display("FAIL %s_bit_timeout actual=bit_ready_low required=bit_accepted", name);
          break;
        end else @(negedge clk);
      end
    end
    @(negedge clk);
    bit_valid = 0; bit_last = 0;
    for (w = 0; w < 80; w++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0 && (err || done_cnt > 0)) break;
    end
    repeat (3) @(negedge clk);
    #3;
    chk({name, "_q_empty"}, exp_q.size(), 0);
    chk({name, "_err"}, err, eerr);
    chk({name, "_done"}, done_cnt, edone);
    chk({name, "_count"}, char_count, ecnt);
    if (eerr) chk({name, "_err_bit_ready"}, bit_ready, 0);
  endtask

  initial begin
    tab_ch[0] = '{97, 110, 117}; tab_code[0] = '{2, 0, 3}; tab_len[0] = '{2, 1, 2};
    tab_ch[1] = '{97, 110, 0};   tab_code[1] = '{2, 0, 0}; tab_len[1] = '{2, 1, 0};
    tab_ch[2] = '{97, 0, 0};     tab_code[2] = '{0, 0, 0}; tab_len[2] = '{0, 0, 0};
    reset = 1; table_load = 0; bit_valid = 0; bit_in = 0; bit_last = 0;
    character = '0; encoded_value = '0; encoded_mask = '0;
    #2;
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_char_count", char_count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); reset = 0;

    load_table(0); rdy_pct = 100; set_stim(5, 'b10011);  run_stream("basic");
    load_table(0); rdy_pct = 35;  set_stim(5, 'b10011);  run_stream("backpressure");
    load_table(1); rdy_pct = 100; set_stim(3, 'b111);    run_stream("invalid");
    load_table(0);                set_stim(3, 'b101);    run_stream("truncated");
    load_table(2);                set_stim(4, 'b0110);   run_stream("single");
    load_table(0);                set_stim(11, 0);       run_stream("overflow");
    load_table(2); rdy_pct = 60;  set_stim(11, 'h5a5);   run_stream("single_ovf");

    // Asynchronous reset in the middle of a stream.
    load_table(0); mon_en = 0; rdy_pct = 100;
    @(negedge clk); bit_valid = 1; bit_in = 0;
    @(negedge clk); bit_in = 1;
    @(negedge clk); bit_valid = 0;
    #3 reset = 1;
    #1;
    chk("mid_rst_bit_ready", bit_ready, 0);
    chk("mid_rst_char_valid", char_valid, 0);
    chk("mid_rst_char_out", char_out, 0);
    chk("mid_rst_char_count", char_count, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk); reset = 0;
    load_table(0); set_stim(5, 'b01100); run_stream("after_reset");

    for (int r = 0; r < 30; r++) begin
      load_table($urandom_range(0, 2));
      rdy_pct = $urandom_range(30, 100);
      set_stim($urandom_range(1, 14), $urandom);
      run_stream("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
